car_request_gen: RTL and testbench
==================================

Name: car_request_gen

Overview:
- Vehicle-detection front end that produces the car_sensor request consumed by the traffic light controller.
- Takes a raw, asynchronous, noisy loop-detector input, then synchronizes and debounces it.
- Latches a service request for the east-west approach and holds it until the controller grants EW green.
- While EW is green, extends the request for a short gap hold after the car leaves. Also reports how long the current or last request waited.

Parameters:
- SYNC_STAGES, 2: flip-flop stages on loop_raw. Legal values ≥ 2.
- DEBOUNCE, 4: consecutive stable synchronized cycles needed to change car_present. Legal values ≥ 1.
- GAP_HOLD, 3: cycles of absence tolerated during service before the request drops. Legal values ≥ 1.
- WAIT_W, 6: width of the saturating wait counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; synchronous, active-low.
- loop_raw  in  1  raw loop detector; asynchronous to clk and may glitch.
- ew_grn  in  1  EW green indication from the traffic controller; synchronous to clk.
- car_present  out  1  debounced vehicle presence.
- car_sensor  out  1  service request to the traffic controller.
- wait_cnt  out  WAIT_W  cycles spent in REQUEST; saturating.
- wait_overflow  out  1  high when wait_cnt equals 2**WAIT_W-1.

Behaviour:
- Reset:
  - rst_n is sampled on the rising edge of clk.
  - While rst_n is low, all of the following are cleared to 0 on every edge: the sync chain, the debounce counter, the gap counter, wait_cnt, and every output.
  - State goes to IDLE.
  - Reset mid-operation discards any pending request. car_sensor is 0 after the first edge with rst_n low.
- Synchronizer:
  - SYNC_STAGES-deep flip-flop chain. sync_q is the last stage.
  - There is no logic between the stages.
- Debounce:
  - The debounce counter clears whenever sync_q == car_present.
  - Otherwise it increments by 1 per edge.
  - On the edge where it would reach DEBOUNCE, car_present toggles and the counter clears.
  - Latency: a clean loop_raw edge (setup met before edge 0) changes car_present after edge SYNC_STAGES+DEBOUNCE (edge 6 with defaults).
  - A pulse shorter than DEBOUNCE synchronized cycles never changes car_present.
- State machine (registered). car_sensor = (state != IDLE), decoded from the registered state.
  - IDLE:
    - If car_present and ew_grn: go to SERVE.
    - Else if car_present: go to REQUEST.
    - Else stay in IDLE.
  - REQUEST:
    - If ew_grn: go to SERVE.
    - Otherwise stay. This is a locking detector: a car leaving does NOT cancel the request.
  - SERVE:
    - The gap counter clears while car_present is 1 and increments while car_present is 0.
    - If ew_grn falls while car_present is 1: go to REQUEST (preempted, re-request).
    - Else if ew_grn falls: go to IDLE.
    - Else if the gap counter would reach GAP_HOLD: go to IDLE.
    - The gap counter clears on every transition into SERVE.
- Simultaneous events:
  - ew_grn falling takes priority over gap expiry.
  - In IDLE, car_present rising together with ew_grn goes directly to SERVE; wait_cnt is untouched.
- Wait counter:
  - Loads 0 on every transition into REQUEST.
  - Increments by 1 on every edge spent in REQUEST, saturating at 2**WAIT_W-1 with no wrap.
  - Holds its value in IDLE and SERVE so it can be read out.
  - wait_overflow is a combinational compare of wait_cnt against 2**WAIT_W-1.
- car_sensor timing: rises one edge after car_present rises (IDLE→REQUEST), i.e. edge SYNC_STAGES+DEBOUNCE+1 after loop_raw rises.

Test Plan (defaults):
- Reset: hold rst_n=0 for 3 cycles with loop_raw=1. All outputs must be 0 during reset. After release, car_present=1 after the 6th edge and car_sensor=1 after the 7th.
- Glitch rejection: from idle, drive loop_raw=1 for 3 cycles, then 0. car_present and car_sensor must stay 0 throughout; wait_cnt stays 0.
- Locking plus gap hold:
  - Drive loop_raw high for 10 cycles, then low, with ew_grn=0.
  - car_sensor must stay 1 after the car leaves, and wait_cnt must keep counting.
  - Assert ew_grn 20 cycles later. car_sensor must stay 1 for 3 more edges, then drop to 0.
  - wait_cnt must hold its value at entry to SERVE.
- Saturation: keep a request pending with ew_grn=0 for 80 cycles. wait_cnt must reach 63, stop there, and wait_overflow=1. Then assert ew_grn: state goes to SERVE and wait_cnt holds 63.
- Preemption: in SERVE with car_present=1, drop ew_grn. car_sensor must stay 1 and wait_cnt must restart from 0 on the next edge, then count.
- Reset mid-REQUEST: assert rst_n=0 for 1 cycle while car_sensor=1. car_sensor=0 and wait_cnt=0 after that edge. The request re-asserts only after a fresh SYNC_STAGES+DEBOUNCE+1 edges of loop_raw=1.

Source files
------------

// File: rtl/car_request_gen.sv
// Loop-detector front end: synchronizes and debounces loop_raw, latches an east-west
// service request until EW green is granted, and measures how long the request waited.
module car_request_gen #(
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 4,
    parameter int GAP_HOLD    = 3,
    parameter int WAIT_W      = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              loop_raw,
    input  logic              ew_grn,
    output logic              car_present,
    output logic              car_sensor,
    output logic [WAIT_W-1:0] wait_cnt,
    output logic              wait_overflow
);
    // state   | meaning
    // IDLE    | no request pending
    // REQUEST | car seen, waiting for EW green (locked until granted)
    // SERVE   | EW green, request held until the car has been gone GAP_HOLD cycles

    localparam int DB_W  = $clog2(DEBOUNCE + 1);
    localparam int GAP_W = $clog2(GAP_HOLD + 1);
    localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP_HOLD - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        SERVE   = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   sync_q;
    logic [DB_W-1:0]        db_cnt;
    logic [GAP_W-1:0]       gap_cnt;

    assign sync_q = sync_ff[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_ff <= '0;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], loop_raw};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            db_cnt      <= '0;
            car_present <= 1'b0;
        end else if (sync_q == car_present) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            db_cnt      <= '0;
            car_present <= ~car_present;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Losing green outranks gap expiry; a car still present when green is pulled re-requests.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (car_present && ew_grn) begin
                    state_nxt = SERVE;
                end else if (car_present) begin
                    state_nxt = REQUEST;
                end
            end
            REQUEST: begin
                if (ew_grn) begin
                    state_nxt = SERVE;
                end
            end
            SERVE: begin
                if (!ew_grn) begin
                    state_nxt = car_present ? REQUEST : IDLE;
                end else if (!car_present && gap_cnt == GAP_LAST) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gap_cnt <= '0;
        end else if (state != SERVE || state_nxt != SERVE || car_present) begin
            gap_cnt <= '0;
        end else begin
            gap_cnt <= gap_cnt + 1'b1;
        end
    end

    // Counts through the exit edge as well, so the held value is the full time spent waiting.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state_nxt == REQUEST && state != REQUEST) begin
            wait_cnt <= '0;
        end else if (state == REQUEST && wait_cnt != WAIT_MAX) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign car_sensor    = (state != IDLE);
    assign wait_overflow = (wait_cnt == WAIT_MAX);

endmodule

// File: tb/tb_car_request_gen.sv
// Bench for car_request_gen: directed scenarios plus random loop/green traffic,
// every cycle compared against a queue-based reference model.
module tb_car_request_gen;
    localparam int SYNC_STAGES = 2;
    localparam int DEBOUNCE    = 4;
    localparam int GAP_HOLD    = 3;
    localparam int WAIT_W      = 6;
    localparam int WAIT_TOP    = (1 << WAIT_W) - 1;

    logic              clk;
    logic              rst_n;
    logic              loop_raw;
    logic              ew_grn;
    logic              car_present;
    logic              car_sensor;
    logic [WAIT_W-1:0] wait_cnt;
    logic              wait_overflow;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model
    bit raw_hist[$];
    bit sync_hist[$];
    bit m_cp;
    bit m_pending;
    bit m_serving;
    int m_absent;
    int m_wait;

    car_request_gen #(
        .SYNC_STAGES(SYNC_STAGES),
        .DEBOUNCE   (DEBOUNCE),
        .GAP_HOLD   (GAP_HOLD),
        .WAIT_W     (WAIT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .loop_raw     (loop_raw),
        .ew_grn       (ew_grn),
        .car_present  (car_present),
        .car_sensor   (car_sensor),
        .wait_cnt     (wait_cnt),
        .wait_overflow(wait_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        raw_hist.delete();
        for (int i = 0; i < SYNC_STAGES; i++) raw_hist.push_back(1'b0);
        sync_hist.delete();
        m_cp      = 1'b0;
        m_pending = 1'b0;
        m_serving = 1'b0;
        m_absent  = 0;
        m_wait    = 0;
    endtask

    task automatic model_edge(input bit r, input bit g, input bit rn);
        bit sq;
        bit cp;
        bit all_differ;
        if (!rn) begin
            model_reset();
            return;
        end
        cp = m_cp;
        sq = raw_hist.pop_front();
        raw_hist.push_back(r);
        sync_hist.push_back(sq);
        if (sync_hist.size() > DEBOUNCE) void'(sync_hist.pop_front());
        all_differ = (sync_hist.size() == DEBOUNCE);
        foreach (sync_hist[i]) if (sync_hist[i] == cp) all_differ = 1'b0;
        if (all_differ) m_cp = ~cp;

        if (m_serving) begin
            if (!g) begin
                m_serving = 1'b0;
                if (cp) begin
                    m_pending = 1'b1;
                    m_wait    = 0;
                end
            end else if (!cp) begin
                m_absent++;
                if (m_absent >= GAP_HOLD) m_serving = 1'b0;
            end else begin
                m_absent = 0;
            end
        end else if (m_pending) begin
            if (m_wait < WAIT_TOP) m_wait++;
            if (g) begin
                m_pending = 1'b0;
                m_serving = 1'b1;
                m_absent  = 0;
            end
        end else if (cp) begin
            if (g) begin
                m_serving = 1'b1;
                m_absent  = 0;
            end else begin
                m_pending = 1'b1;
                m_wait    = 0;
            end
        end
    endtask

    task automatic step(input bit r, input bit g, input bit rn);
        loop_raw = r;
        ew_grn   = g;
        rst_n    = rn;
        @(posedge clk);
        model_edge(r, g, rn);
        #1;
        check("car_present", int'(car_present), int'(m_cp));
        check("car_sensor", int'(car_sensor), int'(m_pending | m_serving));
        check("wait_cnt", int'(wait_cnt), m_wait);
        check("wait_overflow", int'(wait_overflow), int'(m_wait == WAIT_TOP));
    endtask

    initial begin
        bit r;
        bit g;
        loop_raw = 1'b0;
        ew_grn   = 1'b0;
        rst_n    = 1'b0;
        model_reset();

        // reset with the loop already occupied, then release
        repeat (3) step(1'b1, 1'b0, 1'b0);
        check("rst_sensor", int'(car_sensor), 0);
        for (int k = 1; k <= 7; k++) begin
            step(1'b1, 1'b0, 1'b1);
            if (k == 5) check("cp_before_lat", int'(car_present), 0);
            if (k == 6) check("cp_at_lat", int'(car_present), 1);
            if (k == 6) check("sensor_before_lat", int'(car_sensor), 0);
            if (k == 7) check("sensor_at_lat", int'(car_sensor), 1);
        end

        // glitch rejection from idle
        step(1'b0, 1'b0, 1'b0);
        repeat (10) step(1'b0, 1'b0, 1'b1);
        repeat (3) step(1'b1, 1'b0, 1'b1);
        repeat (10) step(1'b0, 1'b0, 1'b1);
        check("glitch_cp", int'(car_present), 0);
        check("glitch_sensor", int'(car_sensor), 0);
        check("glitch_wait", int'(wait_cnt), 0);

        // locking request, then gap hold once green arrives
        repeat (10) step(1'b1, 1'b0, 1'b1);
        repeat (20) step(1'b0, 1'b0, 1'b1);
        check("lock_sensor", int'(car_sensor), 1);
        check("lock_wait", int'(wait_cnt), 23);
        for (int k = 1; k <= 4; k++) begin
            step(1'b0, 1'b1, 1'b1);
            check("gap_sensor", int'(car_sensor), (k < 4) ? 1 : 0);
            check("gap_wait_hold", int'(wait_cnt), 24);
        end

        // saturation
        repeat (80) step(1'b1, 1'b0, 1'b1);
        check("sat_wait", int'(wait_cnt), WAIT_TOP);
        check("sat_ovf", int'(wait_overflow), 1);
        repeat (5) step(1'b1, 1'b1, 1'b1);
        check("sat_serve_wait", int'(wait_cnt), WAIT_TOP);
        check("sat_serve_sensor", int'(car_sensor), 1);

        // preemption while the car is still present
        step(1'b1, 1'b0, 1'b1);
        check("preempt_sensor", int'(car_sensor), 1);
        check("preempt_wait0", int'(wait_cnt), 0);
        step(1'b1, 1'b0, 1'b1);
        check("preempt_wait1", int'(wait_cnt), 1);

        // reset mid-request, request rebuilds from scratch
        step(1'b1, 1'b0, 1'b0);
        check("midrst_sensor", int'(car_sensor), 0);
        check("midrst_wait", int'(wait_cnt), 0);
        for (int k = 1; k <= 7; k++) begin
            step(1'b1, 1'b0, 1'b1);
            if (k == 6) check("rereq_before", int'(car_sensor), 0);
            if (k == 7) check("rereq_at", int'(car_sensor), 1);
        end

        // random traffic with occasional resets
        r = 1'b1;
        g = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 6) == 0) r = ~r;
            if ($urandom_range(0, 19) == 0) g = ~g;
            step(r, g, $urandom_range(0, 299) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
